// File: rtl/axi_read_arbiter.sv
// Two-port AXI4 read arbiter: round-robin AR arbitration with per-port outstanding-burst limits,
// R beats routed back to the owning port by the MSB of m_RID.
module axi_read_arbiter #(
    parameter int C_M_AXI_ID_WIDTH   = 8,
    parameter int C_M_AXI_ADDR_WIDTH = 32,
    parameter int C_M_AXI_DATA_WIDTH = 512,
    parameter int MAX_OUTSTANDING    = 16
) (
    input  logic                            ap_clk,
    input  logic                            ap_rst_n,
    input  logic                            s0_ARVALID,
    output logic                            s0_ARREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s0_ARADDR,
    input  logic [1:0]                      s0_ARBURST,
    input  logic [7:0]                      s0_ARLEN,
    input  logic [2:0]                      s0_ARSIZE,
    input  logic [C_M_AXI_ID_WIDTH-2:0]     s0_ARID,
    output logic                            s0_RVALID,
    input  logic                            s0_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s0_RDATA,
    output logic                            s0_RLAST,
    output logic [C_M_AXI_ID_WIDTH-2:0]     s0_RID,
    output logic [1:0]                      s0_RRESP,
    input  logic                            s1_ARVALID,
    output logic                            s1_ARREADY,
    input  logic [C_M_AXI_ADDR_WIDTH-1:0]   s1_ARADDR,
    input  logic [1:0]                      s1_ARBURST,
    input  logic [7:0]                      s1_ARLEN,
    input  logic [2:0]                      s1_ARSIZE,
    input  logic [C_M_AXI_ID_WIDTH-2:0]     s1_ARID,
    output logic                            s1_RVALID,
    input  logic                            s1_RREADY,
    output logic [C_M_AXI_DATA_WIDTH-1:0]   s1_RDATA,
    output logic                            s1_RLAST,
    output logic [C_M_AXI_ID_WIDTH-2:0]     s1_RID,
    output logic [1:0]                      s1_RRESP,
    output logic                            m_ARVALID,
    input  logic                            m_ARREADY,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_ARADDR,
    output logic [1:0]                      m_ARBURST,
    output logic [7:0]                      m_ARLEN,
    output logic [2:0]                      m_ARSIZE,
    output logic [C_M_AXI_ID_WIDTH-1:0]     m_ARID,
    input  logic                            m_RVALID,
    output logic                            m_RREADY,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]   m_RDATA,
    input  logic                            m_RLAST,
    input  logic [C_M_AXI_ID_WIDTH-1:0]     m_RID,
    input  logic [1:0]                      m_RRESP,
    output logic                            err_unexpected_r
);
    localparam int IW = C_M_AXI_ID_WIDTH;
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CW-1:0] CntMax = CW'(MAX_OUTSTANDING);
    localparam logic [CW-1:0] CntOne = CW'(1);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic [CW-1:0] cnt0_q, cnt1_q;
    logic          err_q;

    logic idle, elig0, elig1, grant0, grant1;
    logic rsel, r_last_hs, dec0, dec1, unexpected;

    always_comb begin
        // Gated by reset so no upstream handshake can occur while the block is held in reset.
        idle   = ap_rst_n && (state_q == StIdle);
        elig0  = s0_ARVALID && (cnt0_q < CntMax);
        elig1  = s1_ARVALID && (cnt1_q < CntMax);
        grant0 = idle && elig0 && (!elig1 || last_grant_q);
        grant1 = idle && elig1 && (!elig0 || !last_grant_q);
    end

    assign s0_ARREADY = grant0;
    assign s1_ARREADY = grant1;
    assign m_ARVALID  = (state_q == StBusy);

    // R path is purely combinational and independent of the AR FSM.
    assign rsel       = m_RID[IW-1];
    assign m_RREADY   = rsel ? s1_RREADY : s0_RREADY;
    assign s0_RVALID  = m_RVALID && !rsel;
    assign s1_RVALID  = m_RVALID && rsel;
    assign s0_RDATA   = m_RDATA;
    assign s1_RDATA   = m_RDATA;
    assign s0_RLAST   = m_RLAST;
    assign s1_RLAST   = m_RLAST;
    assign s0_RRESP   = m_RRESP;
    assign s1_RRESP   = m_RRESP;
    assign s0_RID     = m_RID[IW-2:0];
    assign s1_RID     = m_RID[IW-2:0];

    assign r_last_hs  = m_RVALID && m_RREADY && m_RLAST;
    assign dec0       = r_last_hs && !rsel && (cnt0_q != '0);
    assign dec1       = r_last_hs && rsel && (cnt1_q != '0);
    assign unexpected = r_last_hs && (rsel ? (cnt1_q == '0) : (cnt0_q == '0));

    assign err_unexpected_r = err_q;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q      <= StIdle;
            last_grant_q <= 1'b1;
            m_ARADDR     <= '0;
            m_ARBURST    <= '0;
            m_ARLEN      <= '0;
            m_ARSIZE     <= '0;
            m_ARID       <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (grant0 || grant1) begin
                        state_q      <= StBusy;
                        last_grant_q <= grant1;
                        m_ARADDR     <= grant1 ? s1_ARADDR : s0_ARADDR;
                        m_ARBURST    <= grant1 ? s1_ARBURST : s0_ARBURST;
                        m_ARLEN      <= grant1 ? s1_ARLEN : s0_ARLEN;
                        m_ARSIZE     <= grant1 ? s1_ARSIZE : s0_ARSIZE;
                        m_ARID       <= grant1 ? {1'b1, s1_ARID} : {1'b0, s0_ARID};
                    end
                end
                StBusy: begin
                    if (m_ARREADY) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
            err_q  <= 1'b0;
        end else begin
            if (grant0 && !dec0) begin
                cnt0_q <= cnt0_q + CntOne;
            end else if (!grant0 && dec0) begin
                cnt0_q <= cnt0_q - CntOne;
            end
            if (grant1 && !dec1) begin
                cnt1_q <= cnt1_q + CntOne;
            end else if (!grant1 && dec1) begin
                cnt1_q <= cnt1_q - CntOne;
            end
            if (unexpected) begin
                err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: transaction-level model compared every cycle,
// directed scenarios for the called-out corner cases, then a randomized soak.
module tb_axi_read_arbiter;
    localparam int IW = 8;
    localparam int AW = 32;
    localparam int DW = 512;
    localparam int MAXO = 16;

    logic ap_clk = 1'b0;
    logic ap_rst_n;
    logic s0_ARVALID, s0_ARREADY, s1_ARVALID, s1_ARREADY;
    logic [AW-1:0] s0_ARADDR, s1_ARADDR, m_ARADDR;
    logic [1:0] s0_ARBURST, s1_ARBURST, m_ARBURST;
    logic [7:0] s0_ARLEN, s1_ARLEN, m_ARLEN;
    logic [2:0] s0_ARSIZE, s1_ARSIZE, m_ARSIZE;
    logic [IW-2:0] s0_ARID, s1_ARID, s0_RID, s1_RID;
    logic s0_RVALID, s0_RREADY, s0_RLAST, s1_RVALID, s1_RREADY, s1_RLAST;
    logic [DW-1:0] s0_RDATA, s1_RDATA, m_RDATA;
    logic [1:0] s0_RRESP, s1_RRESP, m_RRESP;
    logic m_ARVALID, m_ARREADY, m_RVALID, m_RREADY, m_RLAST;
    logic [IW-1:0] m_ARID, m_RID;
    logic err_unexpected_r;

    always #5 ap_clk = ~ap_clk;

    axi_read_arbiter #(
        .C_M_AXI_ID_WIDTH(IW), .C_M_AXI_ADDR_WIDTH(AW),
        .C_M_AXI_DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .s0_ARVALID(s0_ARVALID), .s0_ARREADY(s0_ARREADY), .s0_ARADDR(s0_ARADDR),
        .s0_ARBURST(s0_ARBURST), .s0_ARLEN(s0_ARLEN), .s0_ARSIZE(s0_ARSIZE), .s0_ARID(s0_ARID),
        .s0_RVALID(s0_RVALID), .s0_RREADY(s0_RREADY), .s0_RDATA(s0_RDATA), .s0_RLAST(s0_RLAST),
        .s0_RID(s0_RID), .s0_RRESP(s0_RRESP),
        .s1_ARVALID(s1_ARVALID), .s1_ARREADY(s1_ARREADY), .s1_ARADDR(s1_ARADDR),
        .s1_ARBURST(s1_ARBURST), .s1_ARLEN(s1_ARLEN), .s1_ARSIZE(s1_ARSIZE), .s1_ARID(s1_ARID),
        .s1_RVALID(s1_RVALID), .s1_RREADY(s1_RREADY), .s1_RDATA(s1_RDATA), .s1_RLAST(s1_RLAST),
        .s1_RID(s1_RID), .s1_RRESP(s1_RRESP),
        .m_ARVALID(m_ARVALID), .m_ARREADY(m_ARREADY), .m_ARADDR(m_ARADDR),
        .m_ARBURST(m_ARBURST), .m_ARLEN(m_ARLEN), .m_ARSIZE(m_ARSIZE), .m_ARID(m_ARID),
        .m_RVALID(m_RVALID), .m_RREADY(m_RREADY), .m_RDATA(m_RDATA), .m_RLAST(m_RLAST),
        .m_RID(m_RID), .m_RRESP(m_RRESP),
        .err_unexpected_r(err_unexpected_r)
    );

    // Model: outstanding bursts per port, last winner, at most one downstream AR pending.
    int mcnt[2];
    int mlast;
    bit mpend;
    logic [52:0] mfields;  // {addr, burst, len, size, id}
    bit merr;
    int tests = 0;
    int fails = 0;
    int dut_log[$];        // port index of each downstream AR handshake seen on the DUT

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mcnt[0] = 0;
        mcnt[1] = 0;
        mlast = 1;
        mpend = 0;
        mfields = '0;
        merr = 0;
    endtask

    // Called at a negedge with inputs set: compares, then advances the model across one posedge.
    task automatic step();
        int g;
        bit e0, e1, sel, rrdy;
        #1;
        g = -1;
        e0 = s0_ARVALID && (mcnt[0] < MAXO);
        e1 = s1_ARVALID && (mcnt[1] < MAXO);
        if (ap_rst_n && !mpend) begin
            if (e0 && (!e1 || mlast == 1)) g = 0;
            else if (e1) g = 1;
        end
        sel  = m_RID[IW-1];
        rrdy = sel ? s1_RREADY : s0_RREADY;
        chk("s0_arready", s0_ARREADY, g == 0);
        chk("s1_arready", s1_ARREADY, g == 1);
        chk("m_arvalid", m_ARVALID, mpend);
        chk("m_ar_fields", {m_ARADDR, m_ARBURST, m_ARLEN, m_ARSIZE, m_ARID}, mfields);
        chk("m_rready", m_RREADY, rrdy);
        chk("s_rvalid", {s0_RVALID, s1_RVALID}, {m_RVALID && !sel, m_RVALID && sel});
        chk("s0_rdata", s0_RDATA, m_RDATA);
        chk("s1_rdata", s1_RDATA, m_RDATA);
        chk("s_r_side", {s0_RLAST, s0_RRESP, s0_RID, s1_RLAST, s1_RRESP, s1_RID},
            {m_RLAST, m_RRESP, m_RID[IW-2:0], m_RLAST, m_RRESP, m_RID[IW-2:0]});
        chk("err_unexpected_r", err_unexpected_r, merr);
        if (m_ARVALID && m_ARREADY) dut_log.push_back(int'(m_ARID[IW-1]));
        @(posedge ap_clk);
        if (ap_rst_n) begin
            if (m_RVALID && rrdy && m_RLAST) begin
                if (mcnt[sel] == 0) merr = 1;
                else mcnt[sel]--;
            end
            if (g >= 0) begin
                mcnt[g]++;
                mlast = g;
                mpend = 1;
                mfields = (g == 0) ? {s0_ARADDR, s0_ARBURST, s0_ARLEN, s0_ARSIZE, 1'b0, s0_ARID}
                                   : {s1_ARADDR, s1_ARBURST, s1_ARLEN, s1_ARSIZE, 1'b1, s1_ARID};
            end else if (mpend && m_ARREADY) begin
                mpend = 0;
            end
        end
        @(negedge ap_clk);
    endtask

    task automatic quiet_inputs();
        s0_ARVALID = 0; s1_ARVALID = 0; m_ARREADY = 0; m_RVALID = 0; m_RLAST = 0;
        s0_RREADY = 0; s1_RREADY = 0; m_RID = '0; m_RRESP = '0; m_RDATA = '0;
        s0_ARADDR = '0; s0_ARBURST = '0; s0_ARLEN = '0; s0_ARSIZE = '0; s0_ARID = '0;
        s1_ARADDR = '0; s1_ARBURST = '0; s1_ARLEN = '0; s1_ARSIZE = '0; s1_ARID = '0;
    endtask

    // Asserted at a negedge, i.e. mid-cycle, to exercise the asynchronous path.
    task automatic do_reset();
        ap_rst_n = 0;
        #1;
        chk("rst_async_arvalid", m_ARVALID, 1'b0);
        model_reset();
        dut_log.delete();
        step();
        step();
        ap_rst_n = 1;
    endtask

    task automatic rand_ar(input int k);
        if (k == 0) begin
            s0_ARADDR = $urandom; s0_ARBURST = 2'($urandom); s0_ARLEN = 8'($urandom);
            s0_ARSIZE = 3'($urandom); s0_ARID = 7'($urandom);
        end else begin
            s1_ARADDR = $urandom; s1_ARBURST = 2'($urandom); s1_ARLEN = 8'($urandom);
            s1_ARSIZE = 3'($urandom); s1_ARID = 7'($urandom);
        end
    endtask

    task automatic rand_cycle(input int unexp_pct);
        int p;
        s0_ARVALID = ($urandom_range(0, 99) < 70);
        s1_ARVALID = ($urandom_range(0, 99) < 70);
        rand_ar(0);
        rand_ar(1);
        m_ARREADY = $urandom_range(0, 1);
        s0_RREADY = $urandom_range(0, 1);
        s1_RREADY = $urandom_range(0, 1);
        m_RVALID  = ($urandom_range(0, 99) < 50);
        p = (mcnt[0] > 0 && mcnt[1] > 0) ? $urandom_range(0, 1) : (mcnt[1] > 0 ? 1 : 0);
        if ($urandom_range(0, 99) < unexp_pct) p = $urandom_range(0, 1);
        m_RID = {p[0], 7'($urandom)};
        m_RLAST = ($urandom_range(0, 99) < 40) &&
                  (mcnt[p] > 0 || $urandom_range(0, 99) < unexp_pct);
        m_RRESP = 2'($urandom);
        for (int i = 0; i < DW / 32; i++) m_RDATA[i*32 +: 32] = $urandom;
        step();
    endtask

    initial begin
        int beats, n0;
        quiet_inputs();
        ap_rst_n = 0;
        model_reset();
        @(negedge ap_clk);
        step();
        chk("reset_m_arvalid", m_ARVALID, 1'b0);
        chk("reset_m_araddr", m_ARADDR, 32'h0);
        chk("reset_err", err_unexpected_r, 1'b0);
        ap_rst_n = 1;
        step();

        // Both ports requesting, downstream always ready: strict alternation, one AR per 2 cycles.
        do_reset();
        s0_ARVALID = 1; s1_ARVALID = 1; m_ARREADY = 1;
        s0_ARADDR = 32'hA000; s1_ARADDR = 32'hB000;
        for (int i = 0; i < 8; i++) step();
        chk("rr_count", dut_log.size(), 4);
        chk("rr_grant0", dut_log[0], 0);
        chk("rr_grant1", dut_log[1], 1);
        chk("rr_grant2", dut_log[2], 0);
        chk("rr_grant3", dut_log[3], 1);

        // Stalled downstream: registered AR must hold still.
        quiet_inputs();
        do_reset();
        s0_ARVALID = 1; s0_ARADDR = 32'h1000; s0_ARLEN = 8'd7; s0_ARID = 7'h05;
        step();
        s0_ARVALID = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_addr", m_ARADDR, 32'h1000);
            chk("hold_id", m_ARID, 8'h05);
            chk("hold_len", m_ARLEN, 8'd7);
            chk("hold_valid", m_ARVALID, 1'b1);
        end
        m_ARREADY = 1;
        step();
        chk("hold_released", m_ARVALID, 1'b0);

        // Outstanding limit on port 0, released by one RLAST.
        quiet_inputs();
        do_reset();
        s0_ARVALID = 1; m_ARREADY = 1;
        for (int i = 0; i < 2 * MAXO; i++) begin
            s0_ARADDR = 32'(i * 64);
            step();
        end
        chk("limit_p0_issued", dut_log.size(), MAXO);
        s1_ARVALID = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("limit_s0_blocked", s0_ARREADY, 1'b0);
            step();
        end
        s1_ARVALID = 0;
        n0 = 0;
        foreach (dut_log[i]) if (dut_log[i] == 0) n0++;
        chk("limit_p1_served", dut_log.size() - n0 >= 1, 1'b1);
        m_RVALID = 1; m_RLAST = 1; m_RID = 8'h00; s0_RREADY = 1;
        step();
        m_RVALID = 0; m_RLAST = 0;
        for (int i = 0; i < 4; i++) step();
        n0 = 0;
        foreach (dut_log[i]) if (dut_log[i] == 0) n0++;
        chk("limit_p0_resumed", n0, MAXO + 1);

        // Burst back to port 1 with a toggling ready, then an unexpected RLAST.
        quiet_inputs();
        do_reset();
        s1_ARVALID = 1; s1_ARID = 7'h03;
        step();
        s1_ARVALID = 0; m_ARREADY = 1;
        step();
        m_RVALID = 1; m_RID = 8'h83;
        beats = 0;
        for (int i = 0; i < 40 && beats < 4; i++) begin
            s1_RREADY = (i % 2 == 1) || ($urandom_range(0, 3) == 0);
            m_RLAST = (beats == 3);
            #1;
            chk("r_route_s1", {s0_RVALID, s1_RVALID}, 2'b01);
            chk("r_route_id", s1_RID, 7'h03);
            chk("r_rready_mirror", m_RREADY, s1_RREADY);
            step();
            if (s1_RREADY) beats++;
        end
        chk("r_beats_done", beats, 4);
        m_RVALID = 0; m_RLAST = 0;
        step();
        chk("err_clear_before", err_unexpected_r, 1'b0);
        m_RVALID = 1; m_RLAST = 1; s1_RREADY = 1;
        step();
        m_RVALID = 0; m_RLAST = 0;
        chk("err_set", err_unexpected_r, 1'b1);
        for (int i = 0; i < 3; i++) step();
        chk("err_sticky", err_unexpected_r, 1'b1);

        // Reset while BUSY after port 0 won; port 0 must win the first contest again.
        quiet_inputs();
        do_reset();
        s0_ARVALID = 1;
        step();
        s0_ARVALID = 0;
        step();
        chk("busy_before_reset", m_ARVALID, 1'b1);
        do_reset();
        s0_ARVALID = 1; s1_ARVALID = 1; m_ARREADY = 1;
        step();
        step();
        chk("post_reset_first", dut_log.size() > 0 ? dut_log[0] : -1, 0);

        // Randomized soak, mostly legal R traffic, then with unexpected beats allowed.
        quiet_inputs();
        do_reset();
        for (int i = 0; i < 3000; i++) rand_cycle(0);
        do_reset();
        for (int i = 0; i < 1500; i++) rand_cycle(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/axi_read_arbiter.md
AXI_READ_ARBITER -- requirements
Module: axi_read_arbiter

Interface
REQ-001 SHALL have parameter C_M_AXI_ID_WIDTH, default 8, meaning downstream ID width; upstream ID width is C_M_AXI_ID_WIDTH-1.
REQ-002 SHALL have parameter C_M_AXI_ADDR_WIDTH, default 32, meaning address width.
REQ-003 SHALL have parameter C_M_AXI_DATA_WIDTH, default 512, meaning read data width.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 16, meaning maximum in-flight read bursts per upstream port.
REQ-005 SHALL have port ap_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port ap_rst_n, input, 1; reset is asynchronous and active-low.
REQ-007 SHALL have ports s0_ARVALID in 1, s0_ARREADY out 1, s0_ARADDR in ADDR, s0_ARBURST in 2, s0_ARLEN in 8, s0_ARSIZE in 3, s0_ARID in ID-1: upstream read-address channel, port 0.
REQ-008 SHALL have ports s0_RVALID out 1, s0_RREADY in 1, s0_RDATA out DATA, s0_RLAST out 1, s0_RID out ID-1, s0_RRESP out 2: upstream read-data channel, port 0.
REQ-009 SHALL have the identical s1_ set (AR and R) for upstream port 1.
REQ-010 SHALL have ports m_ARVALID out 1, m_ARREADY in 1, m_ARADDR out ADDR, m_ARBURST out 2, m_ARLEN out 8, m_ARSIZE out 3, m_ARID out ID: shared downstream read-address channel.
REQ-011 SHALL have ports m_RVALID in 1, m_RREADY out 1, m_RDATA in DATA, m_RLAST in 1, m_RID in ID, m_RRESP in 2: shared downstream read-data channel.
REQ-012 SHALL have port err_unexpected_r, output, 1: sticky flag, R beat routed to a port with zero outstanding bursts.

Function
REQ-013 AR path SHALL be a two-state FSM: IDLE, BUSY.
REQ-014 Port k eligible when sk_ARVALID=1 and cnt_k < MAX_OUTSTANDING.
REQ-015 In IDLE with at least one eligible port: grant one port, pulse its sk_ARREADY=1 for that cycle, register {ADDR,BURST,LEN,SIZE} and m_ARID={k, sk_ARID}, go BUSY.
REQ-016 Arbitration SHALL be round-robin: when both eligible, grant the port not granted last; last_grant resets to 1 (port 0 wins first contest).
REQ-017 In BUSY: m_ARVALID=1, m_AR* held stable, no sk_ARREADY asserted; on m_ARREADY=1 return to IDLE.
REQ-018 m_ARVALID SHALL be 1 exactly in BUSY; latency upstream accept (cycle t) to m_ARVALID (cycle t+1) SHALL be one cycle; peak throughput one AR per two cycles.
REQ-019 sk_ARREADY SHALL never be 1 while port ineligible, while in BUSY, or for the non-granted port.
REQ-020 cnt_k width SHALL be clog2(MAX_OUTSTANDING+1); increment on port-k AR accept; decrement on R handshake (m_RVALID & m_RREADY & m_RLAST) with m_RID MSB = k; simultaneous increment and decrement leave cnt_k unchanged; cnt_k never exceeds MAX_OUTSTANDING.
REQ-021 R path SHALL be combinational: sel = m_RID[ID-1]; s_sel_RVALID = m_RVALID; other sk_RVALID=0; m_RREADY = s_sel_RREADY.
REQ-022 RDATA, RLAST, RRESP and RID[ID-2:0] SHALL be broadcast to both upstream ports.
REQ-023 R handshake with RLAST for port with cnt=0 SHALL set err_unexpected_r (held until reset); cnt stays 0 (no underflow).
REQ-024 AR and R paths SHALL operate concurrently; R routing never depends on AR FSM state.

Reset
REQ-025 On ap_rst_n=0, asynchronously: FSM to IDLE, m_ARVALID=0, all m_AR* fields 0, cnt_0=cnt_1=0, last_grant=1, err_unexpected_r=0.
REQ-026 During reset sk_ARREADY=0; R-path outputs follow REQ-021 combinationally.
REQ-027 Reset asserted mid-burst SHALL abandon the in-flight AR; no handshake required to recover.

Verification
REQ-028 Both ports assert ARVALID continuously, m_ARREADY=1 -> grants alternate 0,1,0,1; m_ARID MSB matches; one AR every 2 cycles.
REQ-029 s0 ARADDR=0x1000, ARLEN=7, ARID=0x05; m_ARREADY held 0 for 5 cycles -> m_ARADDR=0x1000, m_ARID=0x05 stable until handshake.
REQ-030 Port 0 issues 16 ARs, no R returned -> 17th not accepted (s0_ARREADY=0) while port 1 still granted; one RLAST for port 0 -> next port-0 AR accepted.
REQ-031 m_RID=0x83 beats, RLAST on 4th, s1_RREADY toggling -> only s1_RVALID=1, s1_RID=0x03, m_RREADY mirrors s1_RREADY, cnt_1 decrements once.
REQ-032 RLAST to port 1 with cnt_1=0 -> err_unexpected_r=1 next cycle, stays 1; cnt_1=0.
REQ-033 ap_rst_n=0 while BUSY -> m_ARVALID=0 immediately, counters 0; after release, port 0 wins first contest.
